serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq.sv | 167 ++++++++++++++++
 tb/tb_serial_add_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer. A single 1-bit full-adder cell is reused for
// WIDTH clock cycles to add two WIDTH-bit operands, LSB first. The results
// are registered and change only when an addition completes.
//
// Handshake (valid/ready style): the block is ready when busy=0. A request
// is accepted on the rising edge where busy=0 and start=1; a, b and cin are
// captured on that edge. start while busy=1 is ignored (not queued). Exactly
// WIDTH+1 edges after accept, done pulses high for one cycle and sum/cout/ovf
// hold the new result from that cycle until the next completion or reset.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   request an addition (sampled only when idle)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in
//   busy       out  high while an addition is running or completing
//   done       out  single-cycle completion pulse
//   sum        out  registered WIDTH-bit result
//   cout       out  registered carry out of the MSB
//   ovf        out  registered two's-complement overflow
//   dbg_state  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------

// 1-bit full-adder cell, owned exclusively by the sequencer below.
module serial_add_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_M1  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_c_msb_in;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_psum_next;

    serial_add_fa u_fa (
        .i_a  (r_a[0]),
        .i_b  (r_b[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_last      = (r_cnt == CNT_LAST);
    // Right shift: the bit computed first ends up at index 0 after WIDTH shifts.
    assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_psum     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_c_msb_in <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_psum  <= w_psum_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    // The cell's carry out of bit WIDTH-2 is the carry into the MSB.
                    if (r_cnt == CNT_MSB_M1) begin
                        r_c_msb_in <= w_co;
                    end
                    if (w_last) begin
                        r_sum  <= w_psum_next;
                        r_cout <= w_co;
                        r_ovf  <= r_c_msb_in ^ w_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//
// Directed bench for serial_add_seq with WIDTH=8. A cycle-level model
// (remaining-busy-cycles counter plus plain arithmetic) predicts every output
// and is compared on each falling edge; directed operations additionally
// check hand-computed literal results, latencies and pulse counts.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // remain = cycles of busy left; the final busy cycle is the done cycle.
    int           remain = 0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W+1:0] exp_q[$];   // {ovf, cout, sum} per accepted request
    logic [W+1:0] pend;
    logic [W:0]   full;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            remain = 0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
            exp_q.delete();
        end else if (remain == 0) begin
            if (start) begin
                remain = W + 1;
                full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                exp_q.push_back({((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])), full});
            end
        end else begin
            remain--;
            if (remain == 1) begin
                pend   = exp_q.pop_front();
                m_sum  = pend[W-1:0];
                m_cout = pend[W];
                m_ovf  = pend[W+1];
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, remain != 0);
            check("done", done, remain == 1);
            check("sum",  sum,  m_sum);
            check("cout", cout, m_cout);
            check("ovf",  ovf,  m_ovf);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic, input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        bit ok;
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, ok);
        check({name, "_timeout"}, ok, 1'b1);
        check({name, "_lat"}, n + 1, W + 1);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, eo);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, busy_cnt, done_cnt, gap;
        bit ok;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            check("idle_sum", sum, 8'h00);
            check("idle_state", dbg_state, 2'd0);
        end

        // 5A+3C with busy length measurement
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                check("p1_lat", i + 1, W + 1);
                check("p1_sum", sum, 8'h96);
                check("p1_cout", cout, 1'b0);
                check("p1_ovf", ovf, 1'b1);
            end
            @(negedge clk);
        end
        check("p1_busy_cycles", busy_cnt, W + 1);

        run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("7f00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        run_op("8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("a5c3", 8'hA5, 8'hC3, 1'b1, 8'h69, 1'b1, 1'b1);

        // Start and operand changes during RUN are ignored
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                done_cnt++;
                check("ign_sum", sum, 8'h33);
                check("ign_cout", cout, 1'b0);
            end
            @(negedge clk);
        end
        check("ign_done_cnt", done_cnt, 1);

        // Reset mid-operation
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_state", dbg_state, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("rst_no_done", done_cnt, 0);
        run_op("0102", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // start held high across two operations
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        wait_done(n, ok);
        check("hold1_timeout", ok, 1'b1);
        check("hold1_sum", sum, 8'h30);
        check("hold1_cout", cout, 1'b0);
        a = 8'hF0; b = 8'h20;
        wait_done(gap, ok);
        start = 1'b0;
        check("hold2_timeout", ok, 1'b1);
        check("hold_gap", gap, W + 2);
        check("hold2_sum", sum, 8'h10);
        check("hold2_cout", cout, 1'b1);
        repeat (12) @(negedge clk);
        check("final_idle", busy, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
